// File: rtl/wb_traffic_checker.sv
// wb_traffic_checker: Wishbone burst master that writes a seed+index pattern, reads it back and counts mismatches
module wb_traffic_checker #(
  parameter int dw     = 32,
  parameter int APP_AW = 26,
  parameter int BL_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sdram_resetn,
  input  logic              sdr_init_done,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [APP_AW-1:0] base_addr,
  input  logic [BL_W-1:0]   burst_len,
  input  logic [CNT_W-1:0]  num_bursts,
  input  logic [dw-1:0]     seed,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [APP_AW-1:0] first_err_addr,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);
  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_BEAT, WR_GAP, RD_BEAT, RD_GAP, FINISH} state_t;
  state_t state, state_nx;
  logic [1:0] mode_q;
  logic [APP_AW-1:0] base_q, addr;
  logic [BL_W-1:0] bl_q, beat;
  logic [CNT_W-1:0] nb_q, bursts;
  logic [dw-1:0] seed_q, k, pat;
  logic stb, last;
  assign pat = seed_q + k;
  assign last = beat == bl_q - BL_W'(1);
  // state register
  always_ff @(posedge sys_clk)
    if (!sdram_resetn) state <= IDLE;
    else state <= state_nx;
  // next state and bus/status outputs decoded from state and datapath registers
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? WAIT_INIT : IDLE;
      WAIT_INIT: state_nx = nb_q == '0 ? FINISH : !sdr_init_done ? WAIT_INIT : mode_q == 2'b10 ? RD_BEAT : WR_BEAT;
      WR_BEAT:   state_nx = wb_ack_i && last ? WR_GAP : WR_BEAT;
      WR_GAP:    state_nx = bursts != nb_q ? WR_BEAT : mode_q == 2'b01 ? FINISH : RD_BEAT;
      RD_BEAT:   state_nx = wb_ack_i && last ? RD_GAP : RD_BEAT;
      RD_GAP:    state_nx = bursts != nb_q ? RD_BEAT : FINISH;
      default:   state_nx = IDLE;
    endcase
    stb = state == WR_BEAT || state == RD_BEAT;
    busy = state != IDLE;
    done = state == FINISH;
    wb_cyc_o = stb;
    wb_stb_o = stb;
    wb_we_o = state == WR_BEAT;
    wb_addr_o = addr;
    wb_dat_o = wb_we_o ? pat : '0;
    wb_sel_o = stb ? '1 : '0;
    wb_cti_o = !stb || bl_q == BL_W'(1) ? 3'b000 : last ? 3'b111 : 3'b010;
  end
  // run parameters, beat/burst/address counters and read-check results
  always_ff @(posedge sys_clk)
    if (!sdram_resetn) begin
      mode_q <= '0;
      base_q <= '0;
      bl_q <= '0;
      nb_q <= '0;
      seed_q <= '0;
      addr <= '0;
      beat <= '0;
      bursts <= '0;
      k <= '0;
      err_cnt <= '0;
      first_err_addr <= '0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
      base_q <= base_addr;
      bl_q <= burst_len == '0 ? BL_W'(1) : burst_len;
      nb_q <= num_bursts;
      seed_q <= seed;
      addr <= base_addr;
      beat <= '0;
      bursts <= '0;
      k <= '0;
      err_cnt <= '0;
      first_err_addr <= '0;
    end else if (stb && wb_ack_i) begin
      addr <= addr + APP_AW'(1);
      k <= k + dw'(1);
      beat <= last ? '0 : beat + BL_W'(1);
      bursts <= bursts + CNT_W'(last);
      if (!wb_we_o && wb_dat_i != pat) begin
        err_cnt <= err_cnt == '1 ? err_cnt : err_cnt + CNT_W'(1);
        if (err_cnt == '0) first_err_addr <= addr;
      end
    end else if (state == WR_GAP && state_nx == RD_BEAT) begin
      addr <= base_q;
      k <= '0;
      bursts <= '0;
    end
endmodule

// File: tb/tb_wb_traffic_checker.sv
// tb_wb_traffic_checker: scoreboard bench with a randomized-wait memory responder and a reference run model
module tb_wb_traffic_checker;
  localparam int DW = 32, AW = 26, BLW = 4, CW = 16;
  typedef struct {bit we; logic [AW-1:0] a; logic [DW-1:0] d; logic [2:0] cti; bit last;} beat_t;
  logic clk = 0, rstn = 0, init_done = 0, start = 0;
  logic [1:0] mode = 0;
  logic [AW-1:0] base_addr = 0;
  logic [BLW-1:0] burst_len = 0;
  logic [CW-1:0] num_bursts = 0;
  logic [DW-1:0] seed = 0;
  logic busy, done, cyc, stb, we;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr, addr;
  logic [DW-1:0] dat_o;
  logic [DW/8-1:0] sel;
  logic [2:0] cti;
  logic ack = 0;
  logic [DW-1:0] dat_i = 0;
  beat_t exp_q[$];
  beat_t mon_e;
  logic [DW-1:0] mem [int];
  logic [DW-1:0] ref_mem [int];
  int vectors = 0, miscompares = 0, max_wait = 0, wait_left = -1, gap_st = 0, exp_err = 0;
  logic [AW-1:0] exp_first = 0, corrupt_addr = 0, hold_addr = 0;
  logic hold = 0, hold_we = 0, corrupt_en = 0;
  logic [2:0] hold_cti = 0;

  wb_traffic_checker #(.dw(DW), .APP_AW(AW), .BL_W(BLW), .CNT_W(CW)) dut (
    .sys_clk(clk), .sdram_resetn(rstn), .sdr_init_done(init_done), .start(start), .mode(mode),
    .base_addr(base_addr), .burst_len(burst_len), .num_bursts(num_bursts), .seed(seed),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_addr_o(addr), .wb_dat_o(dat_o),
    .wb_sel_o(sel), .wb_cti_o(cti), .wb_ack_i(ack), .wb_dat_i(dat_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {6'h2A, a} ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [DW-1:0] bus_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v = mem.exists(int'(a)) ? mem[int'(a)] : init_val(a);
    return (corrupt_en && a == corrupt_addr) ? v ^ 32'h0000_0100 : v;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    return (corrupt_en && a == corrupt_addr) ? v ^ 32'h0000_0100 : v;
  endfunction

  function automatic logic [2:0] cti_of(input int idx, input int bl);
    return bl == 1 ? 3'b000 : idx == bl - 1 ? 3'b111 : 3'b010;
  endfunction

  task automatic model_run(input logic [1:0] m, input logic [AW-1:0] b, input logic [BLW-1:0] bl_in,
                           input logic [CW-1:0] nb, input logic [DW-1:0] sd);
    int bl = bl_in == 0 ? 1 : int'(bl_in);
    int total = bl * int'(nb);
    logic [AW-1:0] a;
    logic [DW-1:0] p;
    beat_t e;
    exp_err = 0;
    exp_first = '0;
    if (m != 2'b10)
      for (int i = 0; i < total; i++) begin
        a = b + AW'(i);
        p = sd + DW'(i);
        e = '{1'b1, a, p, cti_of(i % bl, bl), (i % bl) == bl - 1};
        exp_q.push_back(e);
        ref_mem[int'(a)] = p;
      end
    if (m != 2'b01)
      for (int i = 0; i < total; i++) begin
        a = b + AW'(i);
        p = sd + DW'(i);
        if (ref_rd(a) != p) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
        e = '{1'b0, a, p, cti_of(i % bl, bl), (i % bl) == bl - 1};
        exp_q.push_back(e);
      end
  endtask

  // memory responder and scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      ack = 0;
      wait_left = -1;
      gap_st = 0;
      hold = 0;
      exp_q.delete();
    end else begin
      if (!init_done) chk("cyc_before_init", 64'(cyc), 64'd0);
      if (hold) chk("stb_hold", 64'({stb, we, addr, cti}), 64'({1'b1, hold_we, hold_addr, hold_cti}));
      if (gap_st == 2) begin
        if (exp_q.size() > 0) chk("burst_after_gap", 64'(stb), 64'd1);
        else chk("done_after_gap", 64'(done), 64'd1);
        gap_st = 0;
      end
      if (gap_st == 1) begin
        chk("gap_idle", 64'(stb), 64'd0);
        gap_st = 2;
      end
      if (stb) begin
        if (wait_left < 0) wait_left = int'($urandom_range(max_wait, 0));
        ack = wait_left == 0;
        wait_left = ack ? -1 : wait_left - 1;
      end else begin
        ack = 0;
        wait_left = -1;
      end
      hold = stb && !ack;
      hold_we = we;
      hold_addr = addr;
      hold_cti = cti;
      if (ack) begin
        if (we) mem[int'(addr)] = dat_o;
        else dat_i = bus_rd(addr);
        chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_we_addr_cti_sel", 64'({cyc, we, addr, cti, sel}), 64'({1'b1, mon_e.we, mon_e.a, mon_e.cti, 4'hF}));
          if (mon_e.we) chk("write_data", 64'(dat_o), 64'(mon_e.d));
          if (mon_e.last) gap_st = 1;
        end
      end
    end
  end

  task automatic kick(input logic [1:0] m, input logic [AW-1:0] b, input logic [BLW-1:0] bl,
                      input logic [CW-1:0] nb, input logic [DW-1:0] sd);
    @(posedge clk); #1;
    mode = m; base_addr = b; burst_len = bl; num_bursts = nb; seed = sd; start = 1;
    @(posedge clk); #1;
    start = 0; mode = ~m; base_addr = ~b; burst_len = ~bl; num_bursts = ~nb; seed = ~sd;
  endtask

  task automatic run(input logic [1:0] m, input logic [AW-1:0] b, input logic [BLW-1:0] bl,
                     input logic [CW-1:0] nb, input logic [DW-1:0] sd, input int init_delay, input int poke);
    int n = 1;
    model_run(m, b, bl, nb, sd);
    if (init_delay > 0) init_done = 0;
    kick(m, b, bl, nb, sd);
    chk("busy_after_start", 64'(busy), 64'd1);
    while (!done && n < 20000) begin
      if (n == init_delay) init_done = 1;
      start = n == poke;
      @(posedge clk); #1;
      n++;
      if (n == 2 && init_delay == 0) chk("start_to_cyc", 64'({cyc, done}), nb == 0 ? 64'd1 : 64'd2);
    end
    start = 0;
    init_done = 1;
    chk("done_seen", 64'(done), 64'd1);
    chk("err_cnt", 64'(err_cnt), 64'(exp_err > 65535 ? 65535 : exp_err));
    chk("first_err_addr", 64'(first_err_addr), 64'(exp_first));
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    logic seen;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_status", 64'({busy, done, err_cnt, first_err_addr}), 64'd0);
    chk("reset_bus", 64'({cyc, stb, we, addr, sel, cti}), 64'd0);
    chk("reset_dat", 64'(dat_o), 64'd0);
    rstn = 1;
    init_done = 1;
    max_wait = 0;
    run(2'b00, 26'h100, 4'd4, 16'd2, 32'hA5A5_0000, 0, 0);
    corrupt_en = 1;
    corrupt_addr = 26'h105;
    run(2'b00, 26'h100, 4'd4, 16'd2, 32'hA5A5_0000, 0, 0);
    corrupt_en = 0;
    run(2'b00, 26'h3FF_FFFE, 4'd4, 16'd1, 32'h0BAD_F00D, 0, 0);
    run(2'b00, 26'h300, 4'd4, 16'd0, 32'h1111_1111, 0, 0);
    run(2'b00, 26'h400, 4'd0, 16'd3, 32'hFFFF_FFFE, 0, 0);
    run(2'b01, 26'h500, 4'd5, 16'd2, 32'h5000_0000, 0, 0);
    run(2'b10, 26'h500, 4'd5, 16'd2, 32'h5000_0000, 0, 0);
    run(2'b10, 26'h500, 4'd5, 16'd2, 32'h5000_0003, 0, 0);
    max_wait = 5;
    run(2'b00, 26'h600, 4'd7, 16'd3, 32'h6666_0000, 50, 0);
    max_wait = 2;
    run(2'b11, 26'h700, 4'd3, 16'd3, 32'h7777_0000, 0, 6);
    max_wait = 0;
    model_run(2'b00, 26'h200, 4'd4, 16'd2, 32'h1234_0000);
    kick(2'b00, 26'h200, 4'd4, 16'd2, 32'h1234_0000);
    for (int n = 0; n < 100 && exp_q.size() > 14; n++) begin
      @(posedge clk); #1;
    end
    chk("reset_at_beat2", 64'({stb, addr}), 64'({1'b1, 26'h202}));
    rstn = 0;
    @(posedge clk); #1;
    chk("midrun_reset_status", 64'({busy, done, err_cnt, first_err_addr}), 64'd0);
    chk("midrun_reset_bus", 64'({cyc, stb, we, addr, sel, cti}), 64'd0);
    rstn = 1;
    for (int i = 0; i < 8; i++) begin
      mem.delete(32'h200 + i);
      ref_mem.delete(32'h200 + i);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | done | busy | cyc;
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);
    for (int r = 0; r < 8; r++) begin
      max_wait = int'($urandom_range(5, 0));
      run(2'($urandom_range(3, 0)), AW'($urandom), BLW'($urandom_range(15, 0)), CW'($urandom_range(3, 0)), $urandom, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
